// File: rtl/exe_stage.sv
// Execute stage of the 5-stage MIPS pipeline.
// Combinational ALU, destination select and operand forwarding.
// Iterative 32-cycle unsigned multiply/divide unit with HI/LO registers, which raises the stall.
// Optional feature macro: EXE_FORWARD_EN enables MEM/WB operand forwarding.
module exe_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [4:0]        exe_ctrl,
    input  logic [2:0]        md_op,
    input  logic [REG_W-1:0]  rs,
    input  logic [REG_W-1:0]  rt,
    input  logic [REG_W-1:0]  rd,
    input  logic [DATA_W-1:0] read_d1,
    input  logic [DATA_W-1:0] read_d2,
    input  logic [DATA_W-1:0] imm,
    input  logic              mem_regwrite,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_regwrite,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] store_data,
    output logic [REG_W-1:0]  write_reg,
    output logic              out_valid,
    output logic              stall
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_t;

    localparam logic [2:0] MdMultu = 3'b001;
    localparam logic [2:0] MdDivu  = 3'b010;
    localparam logic [2:0] MdMfhi  = 3'b011;
    localparam logic [2:0] MdMflo  = 3'b100;

    state_t              state;
    logic [4:0]          count;
    // acc holds {partial, multiplier} for multu and {remainder, dividend/quotient} for divu
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W-1:0]   opb;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;

    logic [DATA_W-1:0]   fwd_a;
    logic [DATA_W-1:0]   fwd_b;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic                start_mul;
    logic                start_div;

`ifdef EXE_FORWARD_EN
    // MEM result wins over WB data; register 0 is never forwarded
    function automatic logic [DATA_W-1:0] fwd(input logic [REG_W-1:0] idx,
                                              input logic [DATA_W-1:0] rf_val);
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == idx)) begin
            return mem_result;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == idx)) begin
            return wb_data;
        end
        return rf_val;
    endfunction

    // Forwarded operand selection
    always_comb begin
        fwd_a = fwd(rs, read_d1);
        fwd_b = fwd(rt, read_d2);
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd, wb_data, rs};

    // Register file operands used directly
    always_comb begin
        fwd_a = read_d1;
        fwd_b = read_d2;
    end
`endif

    // Operand, destination and ALU result selection
    always_comb begin
        op_a       = fwd_a;
        op_b       = exe_ctrl[4] ? imm : fwd_b;
        store_data = fwd_b;
        write_reg  = exe_ctrl[3] ? rd : rt;
        unique case (exe_ctrl[2:0])
            3'b000:  alu_result = op_a + op_b;
            3'b001:  alu_result = op_a - op_b;
            3'b010:  alu_result = op_a & op_b;
            3'b011:  alu_result = op_a | op_b;
            3'b100:  alu_result = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            3'b101:  alu_result = ~(op_a | op_b);
            3'b110:  alu_result = fwd_b << imm[10:6];
            default: alu_result = {imm[15:0], 16'h0000};
        endcase
        if (md_op == MdMfhi) begin
            alu_result = hi;
        end else if (md_op == MdMflo) begin
            alu_result = lo;
        end
    end

    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W+1:0]   div_diff;
    logic                div_ok;
    logic [2*DATA_W-1:0] div_next;

    // One shift-add multiply step and one restoring divide step
    always_comb begin
        mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opb} : '0);
        mul_next  = {mul_sum, acc[DATA_W-1:1]};
        div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb};
        div_ok    = ~div_diff[DATA_W+1];
        div_next  = {(div_ok ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0]),
                     acc[DATA_W-2:0], div_ok};
    end

    // Start decode and stall generation; stall is forced low during reset
    always_comb begin
        start_mul = in_valid && (md_op == MdMultu);
        start_div = in_valid && (md_op == MdDivu);
        stall     = !rst && (((state == StIdle) && (start_mul || start_div)) ||
                             (state == StMul) || (state == StDiv));
        out_valid = in_valid && !stall;
    end

    // Multiply/divide FSM with HI/LO written only on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
            count <= '0;
            acc   <= '0;
            opb   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start_mul || start_div) begin
                        acc   <= {{DATA_W{1'b0}}, op_a};
                        opb   <= op_b;
                        count <= '0;
                        state <= start_mul ? StMul : StDiv;
                    end
                end
                StMul: begin
                    acc   <= mul_next;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        hi    <= mul_next[2*DATA_W-1:DATA_W];
                        lo    <= mul_next[DATA_W-1:0];
                        state <= StDone;
                    end
                end
                StDiv: begin
                    acc   <= div_next;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        hi    <= div_next[2*DATA_W-1:DATA_W];
                        lo    <= div_next[DATA_W-1:0];
                        state <= StDone;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
